// File: rtl/sort_pkg.sv
// Shared types and constants for the sort engine and its stream adapter.
// Imported by the adapter, the sorter and the bench.
package sort_pkg;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AW    = 3;

  // one odd-even transposition pass per element
  localparam int SORT_PASSES = DEPTH;

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RD_ADDR,
    S_RD_DATA
  } state_t;

endpackage

// File: rtl/circuit.sv
// 8 x 8-bit sort engine: write port, start pulse, registered read port.
// Sorts in place with odd-even transposition; ready drops the cycle after start.
module circuit
  import sort_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             wr,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout,
  output logic             ready
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             sorting;
  logic [AW-1:0]    pass;

  assign ready = ~sorting;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      sorting <= 1'b0;
      pass    <= '0;
    end else if (start && !sorting) begin
      sorting <= 1'b1;
      pass    <= '0;
    end else if (sorting) begin
      if (pass == AW'(SORT_PASSES - 1)) begin
        sorting <= 1'b0;
      end
      pass <= pass + AW'(1);
    end
  end

  // even passes swap pairs (0,1),(2,3)..; odd passes (1,2),(3,4)..
  always_ff @(posedge clk) begin
    if (wr && ready) begin
      mem[addr] <= datain;
    end else if (sorting) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if ((i[0] == pass[0]) && (mem[i] > mem[i+1])) begin
          mem[i]   <= mem[i+1];
          mem[i+1] <= mem[i];
        end
      end
    end
    dataout <= mem[addr];
  end

endmodule

// File: rtl/sort_stream_adapter.sv
// Stream adapter around the sort engine: loads 8 beats, sorts,
// then streams the block back out in ascending order.
module sort_stream_adapter
  import sort_pkg::*;
#(
  parameter int DEPTH   = sort_pkg::DEPTH,
  parameter int WIDTH   = sort_pkg::WIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             err,
  output logic             srt_start,
  output logic             srt_wr,
  output logic [AW-1:0]    srt_addr,
  output logic [WIDTH-1:0] srt_datain,
  input  logic [WIDTH-1:0] srt_dataout,
  input  logic             srt_ready
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state, state_n;
  logic [AW-1:0] wr_cnt, wr_cnt_n;
  logic [AW-1:0] rd_cnt, rd_cnt_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic          err_n;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= S_LOAD;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      wr_cnt  <= wr_cnt_n;
      rd_cnt  <= rd_cnt_n;
      tmo_cnt <= tmo_cnt_n;
      err     <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    wr_cnt_n  = wr_cnt;
    rd_cnt_n  = rd_cnt;
    tmo_cnt_n = tmo_cnt;
    err_n     = err;
    unique case (state)
      S_LOAD: begin
        if (in_valid && srt_ready) begin
          if (wr_cnt == LAST) begin
            wr_cnt_n = '0;
            state_n  = S_START;
          end else begin
            wr_cnt_n = wr_cnt + AW'(1);
          end
        end
      end
      S_START: begin
        state_n = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        tmo_cnt_n = '0;
        state_n   = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (srt_ready) begin
          rd_cnt_n = '0;
          state_n  = S_RD_ADDR;
        end else begin
          tmo_cnt_n = tmo_cnt + TW'(1);
          // this cycle brings the count to TIMEOUT
          if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            err_n    = 1'b1;
            wr_cnt_n = '0;
            state_n  = S_LOAD;
          end
        end
      end
      S_RD_ADDR: begin
        state_n = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (out_ready) begin
          if (rd_cnt == LAST) begin
            rd_cnt_n = '0;
            state_n  = S_LOAD;
          end else begin
            rd_cnt_n = rd_cnt + AW'(1);
            state_n  = S_RD_ADDR;
          end
        end
      end
      default: begin
        state_n = S_LOAD;
      end
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    busy       = 1'b1;
    srt_start  = 1'b0;
    srt_wr     = 1'b0;
    srt_addr   = '0;
    srt_datain = '0;
    unique case (state)
      S_LOAD: begin
        busy       = 1'b0;
        in_ready   = srt_ready;
        srt_wr     = in_valid & srt_ready;
        srt_addr   = wr_cnt;
        srt_datain = in_data;
      end
      S_START: begin
        srt_start = 1'b1;
      end
      S_RD_ADDR: begin
        srt_addr = rd_cnt;
      end
      // address held so the registered read data stays put
      S_RD_DATA: begin
        srt_addr  = rd_cnt;
        out_valid = 1'b1;
        out_data  = srt_dataout;
        out_last  = (rd_cnt == LAST);
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_sort_stream_adapter.sv
// Bench for sort_stream_adapter driving the sort engine.
// Expected output is the input block sorted by a queue model.
module tb_sort_stream_adapter;
  import sort_pkg::*;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_ready = 1'b0;
  logic             stall = 1'b0;
  logic             in_ready, out_valid, out_last;
  logic             busy, err, srt_start, srt_wr;
  logic [WIDTH-1:0] out_data, srt_datain, srt_dataout;
  logic [AW-1:0]    srt_addr;
  logic             ready_c, srt_ready;

  int n_chk = 0;
  int n_fail = 0;
  int n_start = 0;
  logic prev_start = 1'b0;

  assign srt_ready = ready_c & ~stall;

  always #5 clk = ~clk;

  sort_stream_adapter #(.TIMEOUT(255)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err),
    .srt_start(srt_start), .srt_wr(srt_wr),
    .srt_addr(srt_addr), .srt_datain(srt_datain),
    .srt_dataout(srt_dataout), .srt_ready(srt_ready)
  );

  circuit u_srt (
    .clk(clk), .nrst(nrst),
    .start(srt_start), .wr(srt_wr),
    .addr(srt_addr), .datain(srt_datain),
    .dataout(srt_dataout), .ready(ready_c)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      if (srt_start) n_start <= n_start + 1;
      if (busy) chk("wr_outside_load", srt_wr, 0);
      if (srt_start) chk("start_one_cycle", prev_start, 0);
      prev_start <= srt_start;
    end else begin
      prev_start <= 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // gap: 0 none, 1 every other cycle, 2 random
  task automatic load_block(input logic [7:0] d[8],
                            input int gap);
    for (int i = 0; i < 8; i++) begin
      int  wc;
      bit  acc;
      wc  = 0;
      acc = 0;
      if (gap == 1 || (gap == 2 && $urandom_range(1, 0) == 1)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = d[i];
      while (!acc && wc < 300) begin
        #1;
        acc = in_ready;
        if (acc) begin
          chk("wr_strobe", srt_wr, 1);
          chk("wr_addr", srt_addr, i);
          chk("wr_data", srt_datain, d[i]);
        end
        @(negedge clk);
        wc++;
      end
      if (!acc) chk("load_accept", acc, 1);
    end
    in_valid = 1'b0;
  endtask

  // mode: 0 always ready, 1 ready 1-in-3, 2 random
  task automatic read_block(input logic [7:0] d[8],
                            input int mode,
                            input logic exp_err);
    logic [7:0] q[$];
    int         j, budget, cyc;
    bit         held, r;
    logic [7:0] hd;
    foreach (d[k]) q.push_back(d[k]);
    q.sort();
    j = 0; budget = 0; cyc = 0; held = 0; hd = '0;
    while (j < 8 && budget < 2000) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'(($urandom_range(1, 0)));
      endcase
      out_ready = r;
      in_valid  = 1'($urandom_range(1, 0));
      in_data   = 8'($urandom);
      #1;
      if (out_valid) begin
        chk("out_data", out_data, q[j]);
        chk("out_last", out_last, (j == 7));
        if (held) chk("out_stable", out_data, hd);
        held = !r;
        hd   = out_data;
        if (r) j++;
      end else begin
        held = 1'b0;
      end
      @(negedge clk);
      cyc++;
      budget++;
    end
    chk("read_count", j, 8);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("idle_after_block", busy, 0);
    chk("err_after_block", err, exp_err);
  endtask

  task automatic run_block(input logic [7:0] d[8],
                           input int gap, input int mode,
                           input logic exp_err);
    int n0;
    n0 = n_start;
    load_block(d, gap);
    read_block(d, mode, exp_err);
    chk("start_pulses", n_start - n0, 1);
  endtask

  initial begin
    logic [7:0] blk[8];

    nrst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_start", srt_start, 0);
    chk("rst_wr", srt_wr, 0);
    chk("rst_addr", srt_addr, 0);
    chk("rst_in_ready", in_ready, 1);
    nrst = 1'b1;
    @(negedge clk);

    blk = '{5, 3, 8, 1, 9, 2, 7, 4};
    run_block(blk, 0, 0, 1'b0);
    run_block(blk, 1, 1, 1'b0);

    blk = '{8'hAA, 8'hAA, 8'hAA, 8'hAA,
            8'hAA, 8'hAA, 8'hAA, 8'hAA};
    run_block(blk, 0, 0, 1'b0);
    blk = '{8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'hFF, 8'h00, 8'hFF, 8'hFF};
    run_block(blk, 0, 2, 1'b0);

    for (int b = 0; b < 6; b++) begin
      foreach (blk[k]) blk[k] = 8'($urandom);
      run_block(blk, 2, 2, 1'b0);
    end

    // reset while the sorter is running
    blk = '{8, 7, 6, 5, 4, 3, 2, 1};
    load_block(blk, 0);
    @(negedge clk);
    @(negedge clk);
    chk("wait_done_busy", busy, 1);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    run_block(blk, 0, 0, 1'b0);

    // sorter never finishes: timeout
    foreach (blk[k]) blk[k] = 8'($urandom);
    load_block(blk, 0);
    stall = 1'b1;
    chk("tmo_start", srt_start, 1);
    repeat (256) @(negedge clk);
    chk("tmo_err_early", err, 0);
    chk("tmo_busy_early", busy, 1);
    @(negedge clk);
    chk("tmo_err_set", err, 1);
    chk("tmo_in_load", busy, 0);
    chk("tmo_in_ready", in_ready, 0);
    stall = 1'b0;
    repeat (5) @(negedge clk);
    chk("tmo_err_sticky", err, 1);
    chk("tmo_ready_back", in_ready, 1);
    foreach (blk[k]) blk[k] = 8'($urandom);
    run_block(blk, 2, 2, 1'b1);

    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    chk("err_cleared", err, 0);
    foreach (blk[k]) blk[k] = 8'($urandom);
    run_block(blk, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
